// File: rtl/dmg_dma_pkg.sv
// Shared types and address constants for the DMG OAM DMA controller.
package dmg_dma_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    READ,
    WRITE
  } dma_state_t;

  localparam logic [15:0] OAM_BASE  = 16'hFE00;
  localparam logic [15:0] HRAM_LO   = 16'hFF80;
  localparam logic [15:0] HRAM_HI   = 16'hFFFE;
  localparam logic [15:0] DMA_REG   = 16'hFF46;
  localparam logic [7:0]  ECHO_MASK = 8'hDF;

endpackage

// File: rtl/dmg_dma_cpu_arb.sv
// CPU access grant: while DMA owns the bus the CPU may only reach HRAM.
module dmg_dma_cpu_arb
  import dmg_dma_pkg::*;
(
  input  logic        dma_busy,
  input  logic [15:0] cpu_addr,
  output logic        cpu_gnt
);

  logic in_hram;

  always_comb begin
    in_hram = (cpu_addr >= HRAM_LO) && (cpu_addr <= HRAM_HI);
    cpu_gnt = ~dma_busy | in_hram;
  end

endmodule

// File: rtl/dmg_oam_dma_ctrl.sv
// OAM DMA sequencer: FF46 write copies DMA_LEN bytes from {page,00h} into OAM.
// Optional macro DMG_OAM_DMA_ECHO_FOLD_EN folds source pages E0h-FFh onto work RAM.
module dmg_oam_dma_ctrl
  import dmg_dma_pkg::*;
#(
  parameter int unsigned DMA_LEN     = 160,
  parameter int unsigned START_DELAY = 1
) (
  input  logic        clk,
  input  logic        res,
  input  logic        reg_wr,
  input  logic [7:0]  reg_wdata,
  output logic [7:0]  reg_rdata,
  input  logic [15:0] cpu_addr,
  output logic        cpu_gnt,
  output logic        dma_busy,
  output logic        bus_sel,
  output logic        dma_rd,
  output logic [15:0] dma_src_addr,
  input  logic [7:0]  dma_din,
  output logic        dma_wr,
  output logic [7:0]  dma_oam_addr,
  output logic [7:0]  dma_dout
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);
  localparam logic [2:0] DLY_LAST = 3'((START_DELAY == 0) ? 0 : START_DELAY - 1);
  localparam dma_state_t START_ST = (START_DELAY == 0) ? READ : DELAY;

  dma_state_t state_q, state_d;
  logic [7:0] index_q, index_d;
  logic [7:0] page_q,  page_d;
  logic [7:0] hold_q,  hold_d;
  logic [2:0] dcnt_q,  dcnt_d;
  logic [7:0] src_page;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= IDLE;
      index_q <= '0;
      page_q  <= '0;
      hold_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      page_q  <= page_d;
      hold_q  <= hold_d;
      dcnt_q  <= dcnt_d;
    end
  end

`ifdef DMG_OAM_DMA_ECHO_FOLD_EN
  assign src_page = (page_q >= 8'hE0) ? (page_q & ECHO_MASK) : page_q;
`else
  assign src_page = page_q;
`endif

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    page_d       = page_q;
    hold_d       = hold_q;
    dcnt_d       = dcnt_q;
    dma_rd       = 1'b0;
    dma_wr       = 1'b0;
    dma_src_addr = '0;
    dma_oam_addr = '0;
    dma_dout     = '0;

    unique case (state_q)
      IDLE: ;
      DELAY: begin
        if (dcnt_q == DLY_LAST) state_d = READ;
        else                    dcnt_d  = dcnt_q + 3'd1;
      end
      READ: begin
        dma_rd       = 1'b1;
        dma_src_addr = {src_page, index_q};
        hold_d       = dma_din;
        state_d      = WRITE;
      end
      WRITE: begin
        dma_wr       = 1'b1;
        dma_oam_addr = index_q;
        dma_dout     = hold_q;
        if (index_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          index_d = index_q + 8'd1;
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase

    // A register write restarts from any state; a READ in flight is dropped,
    // but the strobes above still reflect the current state this cycle.
    if (reg_wr) begin
      page_d  = reg_wdata;
      index_d = '0;
      dcnt_d  = '0;
      hold_d  = hold_q;
      state_d = START_ST;
    end
  end

  assign reg_rdata = page_q;
  assign dma_busy  = (state_q != IDLE);
  assign bus_sel   = (state_q == READ) || (state_q == WRITE);

  dmg_dma_cpu_arb u_arb (
    .dma_busy (dma_busy),
    .cpu_addr (cpu_addr),
    .cpu_gnt  (cpu_gnt)
  );

endmodule

// File: tb/tb_dmg_oam_dma_ctrl.sv
// Scoreboard bench for dmg_oam_dma_ctrl (DMA_LEN=160, START_DELAY=1).
module tb_dmg_oam_dma_ctrl;

  typedef struct {
    bit         is_wr;
    logic [15:0] addr;
    logic [7:0]  data;
  } ev_t;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        reg_wr = 1'b0;
  logic [7:0]  reg_wdata = '0;
  logic [7:0]  reg_rdata;
  logic [15:0] cpu_addr = 16'hC000;
  logic        cpu_gnt;
  logic        dma_busy;
  logic        bus_sel;
  logic        dma_rd;
  logic [15:0] dma_src_addr;
  logic [7:0]  dma_din;
  logic        dma_wr;
  logic [7:0]  dma_oam_addr;
  logic [7:0]  dma_dout;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  busy_cycles = 0;
  int  busy_drops = 0;
  bit  prev_busy = 1'b0;

  always #5 clk = ~clk;

  // Source memory returns the low address byte.
  assign dma_din = dma_src_addr[7:0];

  dmg_oam_dma_ctrl #(.DMA_LEN(160), .START_DELAY(1)) dut (
    .clk          (clk),
    .res          (res),
    .reg_wr       (reg_wr),
    .reg_wdata    (reg_wdata),
    .reg_rdata    (reg_rdata),
    .cpu_addr     (cpu_addr),
    .cpu_gnt      (cpu_gnt),
    .dma_busy     (dma_busy),
    .bus_sel      (bus_sel),
    .dma_rd       (dma_rd),
    .dma_src_addr (dma_src_addr),
    .dma_din      (dma_din),
    .dma_wr       (dma_wr),
    .dma_oam_addr (dma_oam_addr),
    .dma_dout     (dma_dout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [7:0] fold(input logic [7:0] pg);
`ifdef DMG_OAM_DMA_ECHO_FOLD_EN
    return (pg >= 8'hE0) ? (pg & 8'hDF) : pg;
`else
    return pg;
`endif
  endfunction

  task automatic push_rd(input logic [7:0] pg, input logic [7:0] idx);
    ev_t e;
    e.is_wr = 1'b0; e.addr = {fold(pg), idx}; e.data = '0;
    exp_q.push_back(e);
  endtask

  task automatic push_xfer(input logic [7:0] pg, input int n);
    ev_t e;
    for (int i = 0; i < n; i++) begin
      push_rd(pg, 8'(i));
      e.is_wr = 1'b1; e.addr = 16'(i); e.data = 8'(i);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every read or write strobe is matched against the queue head.
  always @(negedge clk) begin
    ev_t e;
    if (!res) begin
      if (dma_busy) busy_cycles++;
      if (prev_busy && !dma_busy) busy_drops++;
      prev_busy = dma_busy;
      if (dma_rd || dma_wr) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {dma_rd, dma_wr, dma_src_addr}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          if (dma_rd) begin
            chk("rd_kind", 32'(e.is_wr), 32'h0);
            chk("rd_src_addr", 32'(dma_src_addr), 32'(e.addr));
            chk("rd_bus_sel", 32'(bus_sel), 32'h1);
          end else begin
            chk("wr_kind", 32'(e.is_wr), 32'h1);
            chk("wr_oam_addr", 32'(dma_oam_addr), 32'(e.addr[7:0]));
            chk("wr_data", 32'(dma_dout), 32'(e.data));
          end
        end
      end
    end
  end

  // Assumes the caller is at a falling edge.
  task automatic write_reg(input logic [7:0] pg);
    reg_wr = 1'b1;
    reg_wdata = pg;
    @(negedge clk);
    reg_wr = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int guard = 0;
    while (dma_busy && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) chk({name, "_timeout"}, 32'h1, 32'h0);
    @(negedge clk);
    chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'h0);
  endtask

  task automatic wait_rd(input logic [15:0] a, input string name);
    int guard = 0;
    while (!(dma_rd && dma_src_addr == a) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) chk({name, "_timeout"}, 32'h1, 32'h0);
  endtask

  task automatic wait_wr(input logic [7:0] a, input string name);
    int guard = 0;
    while (!(dma_wr && dma_oam_addr == a) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) chk({name, "_timeout"}, 32'h1, 32'h0);
  endtask

  initial begin
    int base_busy;
    int base_drops;

    // Reset state
    #2;
    chk("rst_busy", 32'(dma_busy), 32'h0);
    chk("rst_bus_sel", 32'(bus_sel), 32'h0);
    chk("rst_rd_wr", {30'h0, dma_rd, dma_wr}, 32'h0);
    chk("rst_src_addr", 32'(dma_src_addr), 32'h0);
    chk("rst_oam_dout", {16'h0, dma_oam_addr, dma_dout}, 32'h0);
    chk("rst_rdata", 32'(reg_rdata), 32'h0);
    chk("rst_gnt", 32'(cpu_gnt), 32'h1);
    @(negedge clk);
    @(negedge clk);
    res = 1'b0;
    @(negedge clk);

    // Basic copy with arbitration checks
    push_xfer(8'hC1, 160);
    base_busy = busy_cycles;
    write_reg(8'hC1);
    repeat (10) @(negedge clk);
    cpu_addr = 16'hC000; #1 chk("arb_c000_busy", 32'(cpu_gnt), 32'h0);
    @(negedge clk);
    cpu_addr = 16'hFF80; #1 chk("arb_ff80_busy", 32'(cpu_gnt), 32'h1);
    @(negedge clk);
    cpu_addr = 16'hFFFF; #1 chk("arb_ffff_busy", 32'(cpu_gnt), 32'h0);
    @(negedge clk);
    cpu_addr = 16'hFFFE; #1 chk("arb_fffe_busy", 32'(cpu_gnt), 32'h1);
    wait_idle("basic");
    chk("basic_busy_cycles", 32'(busy_cycles - base_busy), 32'd321);
    cpu_addr = 16'hC000; #1 chk("arb_c000_idle", 32'(cpu_gnt), 32'h1);
    @(negedge clk);

    // Restart during READ of index 5
    push_xfer(8'h80, 5);
    push_rd(8'h80, 8'h05);
    push_xfer(8'h90, 160);
    base_busy = busy_cycles;
    write_reg(8'h80);
    wait_rd(16'h8005, "restart_wait");
    write_reg(8'h90);
    chk("restart_rdata", 32'(reg_rdata), 32'h90);
    chk("restart_busy_now", 32'(dma_busy), 32'h1);
    wait_idle("restart");
    chk("restart_busy_cycles", 32'(busy_cycles - base_busy), 32'd333);

    // Back-to-back: new write on final WRITE cycle
    push_xfer(8'hC1, 160);
    push_xfer(8'h20, 160);
    base_busy = busy_cycles;
    base_drops = busy_drops;
    write_reg(8'hC1);
    wait_wr(8'h9F, "b2b_wait");
    write_reg(8'h20);
    chk("b2b_busy_after", 32'(dma_busy), 32'h1);
    wait_idle("b2b");
    chk("b2b_busy_cycles", 32'(busy_cycles - base_busy), 32'd642);
    chk("b2b_busy_drops", 32'(busy_drops - base_drops), 32'd1);

    // Asynchronous reset during WRITE of index 40
    push_xfer(8'h33, 41);
    write_reg(8'h33);
    wait_wr(8'd40, "rst_wait");
    #1 res = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(dma_busy), 32'h0);
    chk("mid_rst_bus_sel", 32'(bus_sel), 32'h0);
    chk("mid_rst_rd_wr", {30'h0, dma_rd, dma_wr}, 32'h0);
    chk("mid_rst_src_addr", 32'(dma_src_addr), 32'h0);
    chk("mid_rst_oam_dout", {16'h0, dma_oam_addr, dma_dout}, 32'h0);
    chk("mid_rst_rdata", 32'(reg_rdata), 32'h0);
    cpu_addr = 16'hC000; #1 chk("mid_rst_gnt", 32'(cpu_gnt), 32'h1);
    chk("mid_rst_queue", 32'(exp_q.size()), 32'h0);
    @(negedge clk);
    res = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_idle", 32'(dma_busy), 32'h0);

    // Echo page source address
    push_xfer(8'hFE, 160);
    write_reg(8'hFE);
    chk("echo_rdata", 32'(reg_rdata), 32'hFE);
    wait_idle("echo");
    chk("echo_rdata_after", 32'(reg_rdata), 32'hFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
